// File: rtl/stage_latch_q_pkg.sv
// Shared latch widths per pipeline stage boundary and the default latch depth.
package stage_latch_q_pkg;

   localparam int unsigned IF_ID_W       = 96;
   localparam int unsigned ID_EX_W       = 256;
   localparam int unsigned EX_WB_W       = 400;
   localparam int unsigned DEFAULT_DEPTH = 2;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/stage_latch_q_if.sv
// Valid/ready handshake bundle between two pipeline stages, plus flush and occupancy.
interface stage_latch_q_if #(
   parameter int unsigned WIDTH = 400,
   parameter int unsigned CNT_W = 2
);
   logic             valid_in;
   logic [WIDTH-1:0] din;
   logic             ready_out;
   logic             valid_out;
   logic [WIDTH-1:0] dout;
   logic             ready_in;
   logic             flush;
   logic [CNT_W-1:0] count;

   modport master (
      output valid_in, din, ready_in, flush,
      input  ready_out, valid_out, dout, count
   );

   modport slave (
      input  valid_in, din, ready_in, flush,
      output ready_out, valid_out, dout, count
   );
endinterface

// File: rtl/stage_latch_q_ptr_ctr.sv
// Mod-DEPTH pointer with increment and synchronous clear; wraps naturally for power-of-two DEPTH.
module stage_latch_q_ptr_ctr #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_inc,
   input  logic                     i_clr,
   output logic [$clog2(DEPTH)-1:0] o_ptr
);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [IDX_W-1:0] r_ptr;

   always_ff @(posedge clk) begin
      if (rst || i_clr)
         r_ptr <= '0;
      else if (i_inc)
         r_ptr <= r_ptr + IDX_W'(1);
   end

   assign o_ptr = r_ptr;
endmodule

// File: rtl/stage_latch_q.sv
// Parametrised inter-stage FIFO latch with valid/ready handshake, squash and occupancy count.
module stage_latch_q
   import stage_latch_q_pkg::*;
#(
   parameter int unsigned WIDTH = EX_WB_W,
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input logic            clk,
   input logic            rst,
   stage_latch_q_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [DEPTH-1:0][WIDTH-1:0] r_mem;
   logic [CNT_W-1:0]            r_count;
   logic [IDX_W-1:0]            w_wr_ptr;
   logic [IDX_W-1:0]            w_rd_ptr;
   logic                        w_valid;
   logic                        w_ready;
   logic                        w_push;
   logic                        w_pop;

   // Handshake depends only on held occupancy, never on ready_in.
   assign w_valid = (r_count != CNT_W'(0));
   assign w_ready = (r_count != CNT_W'(DEPTH));
   assign w_push  = bus.valid_in && w_ready;
   assign w_pop   = w_valid && bus.ready_in;

   stage_latch_q_ptr_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_push),
      .i_clr (bus.flush),
      .o_ptr (w_wr_ptr)
   );

   stage_latch_q_ptr_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_pop),
      .i_clr (bus.flush),
      .o_ptr (w_rd_ptr)
   );

   // Storage is left untouched by flush/reset; output gating hides stale entries.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[w_wr_ptr] <= bus.din;
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush)
         r_count <= '0;
      else
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
   end

   assign bus.ready_out = w_ready;
   assign bus.valid_out = w_valid;
   assign bus.dout      = w_valid ? r_mem[w_rd_ptr] : '0;
   assign bus.count     = r_count;
endmodule

// File: tb/tb_stage_latch_q.sv
// Drives a DEPTH=2 and a DEPTH=4 latch with shared stimulus; a per-latch queue model is checked each cycle.
module tb_stage_latch_q;
   logic       clk = 1'b0;
   logic       rst;
   logic       valid_in;
   logic [7:0] din;
   logic       ready_in;
   logic       flush;
   bit         done = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [7:0] mq [2][$];

   stage_latch_q_if #(.WIDTH(8), .CNT_W(2)) bus2 ();
   stage_latch_q_if #(.WIDTH(8), .CNT_W(3)) bus4 ();

   assign bus2.valid_in = valid_in;
   assign bus2.din      = din;
   assign bus2.ready_in = ready_in;
   assign bus2.flush    = flush;
   assign bus4.valid_in = valid_in;
   assign bus4.din      = din;
   assign bus4.ready_in = ready_in;
   assign bus4.flush    = flush;

   stage_latch_q #(.WIDTH(8), .DEPTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
   stage_latch_q #(.WIDTH(8), .DEPTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Compare the DUT against the model, then advance the model by the upcoming edge.
   task automatic model_cycle(input int d, input int depth, input string tag,
                              input logic vo, input logic ro,
                              input logic [7:0] dq, input logic [3:0] cnt);
      int n;
      bit acc;
      n = mq[d].size();
      chk({tag, "_count"},     int'(cnt), n);
      chk({tag, "_valid_out"}, int'(vo),  int'(n != 0));
      chk({tag, "_ready_out"}, int'(ro),  int'(n != depth));
      chk({tag, "_dout"},      int'(dq),  (n != 0) ? int'(mq[d][0]) : 0);
      if (rst || flush) begin
         mq[d].delete();
      end else begin
         acc = valid_in && (n < depth);
         if (n != 0 && ready_in) void'(mq[d].pop_front());
         if (acc) mq[d].push_back(din);
      end
   endtask

   always @(negedge clk) begin
      if (!done) begin
         model_cycle(0, 2, "d2", bus2.valid_out, bus2.ready_out, bus2.dout, {2'b00, bus2.count});
         model_cycle(1, 4, "d4", bus4.valid_out, bus4.ready_out, bus4.dout, {1'b0, bus4.count});
      end
   end

   task automatic drive(input logic r, input logic v, input logic [7:0] d,
                        input logic ri, input logic f);
      rst = r; valid_in = v; din = d; ready_in = ri; flush = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with a valid bundle presented: it must be discarded.
      drive(1, 1, 8'hAA, 0, 0);
      drive(1, 1, 8'hAA, 0, 0);
      drive(0, 0, 8'h00, 0, 0);

      // Streaming with downstream always ready.
      drive(0, 1, 8'h01, 1, 0);
      drive(0, 1, 8'h02, 1, 0);
      drive(0, 1, 8'h03, 1, 0);
      drive(0, 0, 8'h00, 1, 0);
      drive(0, 0, 8'h00, 1, 0);

      // Backpressure until full, then simultaneous push/pop while full.
      drive(0, 1, 8'h11, 0, 0);
      drive(0, 1, 8'h22, 0, 0);
      drive(0, 1, 8'h33, 0, 0);
      drive(0, 1, 8'h33, 0, 0);
      drive(0, 1, 8'h33, 1, 0);
      drive(0, 1, 8'h33, 1, 0);
      drive(0, 0, 8'h00, 1, 0);
      drive(0, 0, 8'h00, 1, 0);
      drive(0, 0, 8'h00, 1, 0);
      drive(0, 0, 8'h00, 1, 0);

      // Fill, then flush with a same-cycle push and pop.
      drive(0, 1, 8'h44, 0, 0);
      drive(0, 1, 8'h55, 0, 0);
      drive(0, 1, 8'h66, 1, 1);
      drive(0, 0, 8'h00, 1, 0);
      drive(0, 0, 8'h00, 1, 0);

      // Randomised traffic with occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
               8'($urandom), ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 31) == 0));
      end

      drive(0, 0, 8'h00, 1, 0);
      drive(0, 0, 8'h00, 1, 0);
      drive(0, 0, 8'h00, 1, 0);
      drive(0, 0, 8'h00, 1, 0);
      @(negedge clk);
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
